// File: rtl/cr_fifo_sched_pkg.sv
// rtl/cr_fifo_sched_pkg.sv - shared types and helpers for the FIFO round-robin read scheduler
package cr_fifo_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_t;

   // Widest flat head-word bus and widest single word the slicing helper handles.
   localparam int MAX_FLAT_BITS = 4096;
   localparam int MAX_WORD_BITS = 1024;

   // Return port p's word from a zero-extended flat vector; the caller truncates to its width.
   function automatic logic [MAX_WORD_BITS-1:0] slice_port(
      input logic [MAX_FLAT_BITS-1:0] flat,
      input int unsigned              p,
      input int unsigned              word_bits
   );
      logic [MAX_FLAT_BITS-1:0] shifted;
      shifted = flat >> (p * word_bits);
      return shifted[MAX_WORD_BITS-1:0];
   endfunction

endpackage

// File: rtl/cr_rr_pick.sv
// rtl/cr_rr_pick.sv - find first set request at or above a pointer, wrapping past the top
module cr_rr_pick #(
   parameter  int N_PORTS = 4,
   localparam int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   // Scan from the farthest candidate down to ptr itself so the nearest request wins last.
   always_comb begin
      int unsigned idx;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         idx = 32'(ptr) + 32'(i);
         if (idx >= 32'(N_PORTS)) begin
            idx = idx - 32'(N_PORTS);
         end
         if (req[idx[IDX_W-1:0]]) begin
            gnt_idx = idx[IDX_W-1:0];
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cr_fifo_rr_sched.sv
// rtl/cr_fifo_rr_sched.sv - round-robin burst reader draining N FWFT FIFOs into one output stream
module cr_fifo_rr_sched #(
   parameter  int N_PORTS     = 4,
   parameter  int N_DATA_BITS = 64,
   parameter  int N_BURST     = 4,
   localparam int IDX_W       = $clog2(N_PORTS),
   localparam int CNT_W       = $clog2(N_BURST) + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [N_PORTS-1:0]             fifo_empty,
   input  logic [N_PORTS*N_DATA_BITS-1:0] fifo_rdata,
   output logic [N_PORTS-1:0]             fifo_ren,
   output logic                           out_valid,
   output logic [N_DATA_BITS-1:0]         out_data,
   output logic [IDX_W-1:0]               out_src,
   input  logic                           out_ready,
   output logic                           busy
);

   import cr_fifo_sched_pkg::*;

   sched_state_t             state;
   logic [IDX_W-1:0]         grant;
   logic [IDX_W-1:0]         rr_ptr;
   logic [CNT_W-1:0]         burst_cnt;

   logic [IDX_W-1:0]         pick_idx;
   logic                     pick_any;
   logic [IDX_W-1:0]         next_ptr;
   logic                     can_load;
   logic                     head_empty;
   logic                     pop;
   logic                     last_pop;
   logic [MAX_FLAT_BITS-1:0] rdata_ext;
   logic [N_DATA_BITS-1:0]   head_word;

   cr_rr_pick #(
      .N_PORTS (N_PORTS)
   ) u_pick (
      .req     (~fifo_empty),
      .ptr     (rr_ptr),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // The output slot can take a new word when it is empty or being drained this cycle.
   assign can_load   = ~out_valid | out_ready;
   assign head_empty = fifo_empty[grant];
   assign pop        = (state == BURST) & enable & ~head_empty & can_load;
   assign last_pop   = (burst_cnt + CNT_W'(1)) == CNT_W'(N_BURST);
   assign next_ptr   = (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + IDX_W'(1);
   assign busy       = (state != IDLE) | out_valid;

   assign rdata_ext  = MAX_FLAT_BITS'(fifo_rdata);
   assign head_word  = N_DATA_BITS'(slice_port(rdata_ext, 32'(grant), 32'(N_DATA_BITS)));

   // Pop strobe goes only to the granted FIFO.
   always_comb begin
      fifo_ren = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         fifo_ren[p] = pop & (grant == IDX_W'(p));
      end
   end

   // Grant state machine: pick in IDLE, pop up to N_BURST words in BURST, rotate on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && pick_any) begin
                  grant     <= pick_idx;
                  burst_cnt <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (pop) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
                  if (last_pop) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                  end
               end else if (!enable || head_empty) begin
                  // A stall purely from a full output slot keeps the grant.
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: load on pop, clear once accepted, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= head_word;
         out_src   <= grant;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/cr_fifo_rr_sched.md
# cr_fifo_rr_sched

Round-robin read scheduler that drains N_PORTS first-word-fall-through FIFOs into one registered valid/ready output stream. It grants one FIFO at a time, pops up to N_BURST words per grant, then rotates priority. It sits between the per-source FIFO instances and a single shared downstream consumer, and is the only reader of those FIFOs.

## Interface
- N_PORTS, 4: number of source FIFOs, 2..16, not required to be a power of two.
- N_DATA_BITS, 64: word width.
- N_BURST, 4: maximum pops per grant, at least 1.
- clk, in, 1: clock.
- rst, in, 1: reset. One clock; reset is asynchronous and active-high.
- enable, in, 1: scheduler enable. When low, no new grants and no further pops.
- fifo_empty, in, N_PORTS: per-FIFO empty flag.
- fifo_rdata, in, N_PORTS*N_DATA_BITS: per-FIFO head word. Port p occupies bits [p*N_DATA_BITS +: N_DATA_BITS]; the word is valid while fifo_empty[p] is 0.
- fifo_ren, out, N_PORTS: per-FIFO pop, one-hot or zero.
- out_valid, out, 1: output word valid.
- out_data, out, N_DATA_BITS: output word.
- out_src, out, clog2(N_PORTS): index of the source port for out_data.
- out_ready, in, 1: consumer accepts when out_valid is 1 and out_ready is 1.
- busy, out, 1: high when the state is not IDLE or when out_valid is 1.

## Operation
- States: IDLE, BURST. Registers: state, grant (port index), rr_ptr (port index), burst_cnt (width clog2(N_BURST)+1), plus the output register (out_valid, out_data, out_src).
- IDLE:
  - If enable is 1 and any fifo_empty bit is 0, pick the first non-empty port scanning upward from rr_ptr with wrap.
  - Load grant with that port, clear burst_cnt, and go to BURST.
  - Otherwise stay in IDLE.
- can_load = ~out_valid | out_ready.
- pop = (state==BURST) & enable & ~fifo_empty[grant] & can_load.
- fifo_ren[grant] = pop. All other fifo_ren bits are 0.
- On pop:
  - out_data <= fifo_rdata[grant].
  - out_src <= grant.
  - out_valid <= 1.
  - burst_cnt increments.
- If out_valid is 1, out_ready is 1 and there is no pop, out_valid <= 0.
- If out_valid is 1 and out_ready is 0, out_data and out_src hold stable.
- BURST exits to IDLE, with rr_ptr <= (grant+1) mod N_PORTS, on any of:
  - A pop that brings burst_cnt to N_BURST.
  - fifo_empty[grant] is 1 in a cycle with no pop.
  - enable is 0.
- A BURST stall caused only by can_load being 0, with the FIFO non-empty, stays in BURST and keeps the grant.
- rr_ptr wraps from N_PORTS-1 to 0.
- Upstream writes into the granted FIFO during BURST extend the burst, up to N_BURST words.

## Timing
- Reset values:
  - state = IDLE.
  - grant = 0, rr_ptr = 0, burst_cnt = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - fifo_ren = 0, busy = 0.
- Arbitration latency: the first non-empty flag seen in IDLE at cycle t gives the state BURST at t+1. fifo_ren is asserted at t+1 if can_load is 1, and out_valid is 1 at t+2.
- Throughput: 1 word/cycle within a burst when out_ready is held 1.
- Each rotation passes through IDLE, so there is exactly one bubble cycle of fifo_ren between bursts.
- fifo_ren is combinational from registered state plus fifo_empty, enable and out_ready. No combinational path exists from fifo_rdata to any output.
- enable falling mid-burst: pop is 0 in that same cycle, the state reaches IDLE next cycle, and the out_valid word persists until it is accepted.
- rst asserted mid-burst: everything returns to reset values immediately. Any word held in the output register is dropped.

## Structure
- Shared package cr_fifo_sched_pkg holds:
  - The state enum typedef (IDLE, BURST).
  - A function that slices port p from the flat rdata vector.
- Sub-module cr_rr_pick: combinational find-first-set starting at a pointer, with wrap. Inputs: req[N_PORTS], ptr. Outputs: gnt_idx, any. It is reusable by other arbiters.
- Everything else (state machine, counter, output register) lives in cr_fifo_rr_sched.

## Test plan
- Single port: N_PORTS=4, N_BURST=4, port 2 loaded with 3 words, out_ready=1.
  - Grant 2 at cycle 1.
  - fifo_ren[2] high for 3 cycles.
  - out_src=2 for 3 words, in order.
  - The burst ends on empty, and rr_ptr becomes 3.
- Fairness: all 4 ports hold 10 words, N_BURST=4.
  - Output source sequence is 0×4, 1×4, 2×4, 3×4, 0×4, ...
  - One ren bubble occurs between bursts.
  - The rr_ptr wrap from 3 to 0 is checked.
- Backpressure: out_ready toggles at 50% during a burst.
  - No word is lost or duplicated.
  - out_data is stable while stalled.
  - The grant is held through stalls.
  - The burst still ends after exactly 4 pops.
- N_BURST=1, ports 0 and 3 non-empty: sources alternate 0, 3, 0, 3, with IDLE between each pop.
- enable dropped after 2 pops of a 4-word port:
  - No third pop.
  - The state is IDLE next cycle.
  - The pending out_valid word is still delivered.
  - busy stays 1 until that word is accepted.
- rst pulsed mid-burst with out_valid=1: out_valid, fifo_ren, state, rr_ptr and busy are all 0 asynchronously, and scheduling resumes from port 0 after release.
